row_window_server: RTL and testbench
====================================

Name: row_window_server

Overview:
- Responder side of the row-window interface used by the calculator datapath.
- On a `wr_req`/`dst_row` request it reads four consecutive image rows from frame memory into local row buffers.
- It then streams them column by column on `x1_data`..`x4_data` and pulses `tran_done` after the last column.
- It sits between the frame-buffer read port and the calculator.

Parameters:
- IMG_W, 640, pixels per row (number of columns streamed)
- IMG_H, 480, rows in the frame; used for bottom-edge clamping
- DW, 16, pixel width
- AW, 19, frame-memory word address width; must satisfy 2^AW >= IMG_W*IMG_H
- RD_LAT, 1, frame-memory read latency in cycles (1..3)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- dst_row  in  12  top row of the requested 4-row window
- wr_req  in  1  request strobe, one cycle, sampled only in IDLE
- x1_data  out  DW  pixel of window row 0 (dst_row)
- x2_data  out  DW  pixel of window row 1
- x3_data  out  DW  pixel of window row 2
- x4_data  out  DW  pixel of window row 3
- x_valid  out  1  x1..x4 carry a valid column
- tran_done  out  1  one-cycle pulse, window fully delivered
- busy  out  1  high in any state other than IDLE
- rd_en  out  1  frame-memory read enable
- rd_addr  out  AW  frame-memory word address
- rd_data  in  DW  read data, valid RD_LAT cycles after rd_en

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. All outputs reset to 0 and the FSM to IDLE.
  - Row-buffer contents are don't-care after reset.
  - Reset asserted mid-operation aborts immediately; no tran_done is issued.
- FSM states: IDLE, LOAD, DRAIN, STREAM, DONE.
- IDLE:
  - wr_req=1 latches dst_row and goes to LOAD.
  - dst_row >= IMG_H is clamped to IMG_H-1.
  - wr_req in any other state is ignored; there is no queueing.
- LOAD:
  - Window row k (k=0..3) uses source row s_k = min(r+k, IMG_H-1); duplicate rows are legal at the bottom edge.
  - Issues one rd_en per cycle, rd_addr = s_k*IMG_W + col, k-major then col ascending: 4*IMG_W reads.
  - The first rd_en occurs in the cycle after wr_req.
  - A pipelined tag of (k, col) of depth RD_LAT writes rd_data into row buffer k at col.
  - After the last read, go to DRAIN.
- DRAIN: waits RD_LAT cycles for the last captures, then goes to STREAM.
- STREAM:
  - IMG_W cycles with x_valid=1; column c is presented on cycle c.
  - x1..x4 come from row buffers 0..3, registered output.
  - x_valid is never deasserted mid-row; there is no backpressure.
- DONE:
  - tran_done=1 for exactly one cycle, in the cycle immediately after the last x_valid.
  - Then IDLE; busy drops in that same IDLE cycle.
- Idle outputs: x*_data hold their last value when x_valid=0. rd_addr is don't-care when rd_en=0 but is driven 0 in IDLE.
- Latency, full load: wr_req at cycle 0 → first x_valid at cycle 4*IMG_W + RD_LAT + 2 → tran_done at cycle 5*IMG_W + RD_LAT + 2.
- Address arithmetic: unsigned, width AW; no wrap is possible given the AW constraint.

Optional Feature:
- Macro: ROW_REUSE_EN.
- Defined:
  - Keep a tag of the last loaded top row plus a valid bit; the valid bit is cleared by reset.
  - Row buffers are addressed through a 2-bit rotating base pointer.
  - Request r == tag: skip LOAD/DRAIN and go straight to STREAM (first x_valid at cycle 2).
  - Request r == tag+1: load only source row min(r+3, IMG_H-1) into the slot at the base pointer, then base pointer +1 mod 4 (IMG_W reads).
  - Any other r: full 4-row load and base pointer = 0.
- Undefined: every request performs the full 4-row load, the base pointer is fixed at 0, and no tag logic is present.

Decomposition:
- Package calc_pkg holds:
  - state enum (IDLE, LOAD, DRAIN, STREAM, DONE)
  - default IMG_W/IMG_H/DW constants
  - ROW_W = 12 width constant
- Sub-module row_buf: IMG_W x DW simple dual-port RAM (1 write, 1 registered read), instantiated 4x.

Test Plan (IMG_W=8, IMG_H=6, RD_LAT=1; memory model word = row*16+col):
1. Reset, then wr_req with dst_row=1
   - 32 rd_en with addresses 8..39.
   - First x_valid at cycle 35; column 0 gives x1..x4 = 0x10, 0x20, 0x30, 0x40; column 7 gives 0x17, 0x27, 0x37, 0x47.
   - tran_done at cycle 43.
2. dst_row=4 (bottom edge)
   - Rows used are 4, 5, 5, 5; column 2 gives 0x42, 0x52, 0x52, 0x52.
   - dst_row=9 clamps to rows 5, 5, 5, 5.
3. wr_req pulsed during LOAD and during STREAM
   - Ignored; exactly one tran_done per accepted request.
   - Next request in IDLE is accepted normally.
4. rstn asserted mid-STREAM at column 3
   - All outputs 0 immediately; no tran_done.
   - A new request after release streams correct data.
5. RD_LAT=3 build, dst_row=0
   - Data equals memory rows 0..3.
   - First x_valid at cycle 37.
6. ROW_REUSE_EN, requests 0, 1, 1, 3:
   - request 1: full load.
   - request 2: 8 reads (row 4 only); output rows 1..4.
   - request 3: 0 reads; first x_valid at cycle 2.
   - request 4: full load.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the row-window datapath: FSM state encoding,
// default image geometry and the row-index width.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        STREAM,
        DONE
    } state_t;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int DW_DEF    = 16;
    localparam int ROW_W     = 12;

endpackage

// File: rtl/row_buf.sv
// One image row of local storage: simple dual-port RAM with a single write
// port and a registered read port. Contents are never reset.
module row_buf #(
    parameter int DEPTH = 640,
    parameter int DW    = 16,
    localparam int CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [CW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [CW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port: captures one pixel per cycle during the load phase.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port: output holds while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/row_window_server.sv
// Row-window responder: on request, fetches four consecutive frame rows into
// local row buffers and streams them column by column on x1..x4.
// Build option ROW_REUSE_EN: remembers the last window top row so a repeated
// request streams without reloading and a one-row step loads only the new row.
module row_window_server
    import calc_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int DW     = DW_DEF,
    parameter int AW     = 19,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [ROW_W-1:0] dst_row,
    input  logic             wr_req,
    output logic [DW-1:0]    x1_data,
    output logic [DW-1:0]    x2_data,
    output logic [DW-1:0]    x3_data,
    output logic [DW-1:0]    x4_data,
    output logic             x_valid,
    output logic             tran_done,
    output logic             busy,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [DW-1:0]    rd_data
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int SW = $clog2(IMG_W + 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
    localparam logic [CW-1:0]    LAST_COL = CW'(IMG_W - 1);

    // Saturate a row index at the bottom edge of the frame.
    function automatic logic [ROW_W-1:0] clamp_row(input logic [ROW_W:0] r);
        if (r > {1'b0, LAST_ROW}) begin
            return LAST_ROW;
        end
        return r[ROW_W-1:0];
    endfunction

    // Source row for window row k below the given top row.
    function automatic logic [ROW_W-1:0] src_row(input logic [ROW_W-1:0] top,
                                                 input logic [1:0] k);
        return clamp_row({1'b0, top} + {{(ROW_W - 1){1'b0}}, k});
    endfunction

    // Frame-memory word address of (row, col).
    function automatic logic [AW-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                               input logic [CW-1:0] col);
        return AW'(row) * AW'(IMG_W) + AW'(col);
    endfunction

    state_t state, state_nx;

    logic [ROW_W-1:0] req_row, top_row, row_ref;
    logic             req_hit, req_single;
    logic             ld_single, ld_single_nx;
    logic [1:0]       base, ld_k, ld_k_nx, ld_slot, src_k;
    logic [CW-1:0]    ld_col, ld_col_nx;
    logic             ld_last, drain_last;
    logic [1:0]       drn_cnt;
    logic [SW-1:0]    st_col;
    logic             rd_en_nx;
    logic [AW-1:0]    rd_addr_nx;

    logic [3:0]       buf_we;
    logic             buf_re;
    logic [CW-1:0]    buf_raddr;
    logic [DW-1:0]    buf_q [4];

    logic [RD_LAT-1:0] cap_vld_p;
    logic [1:0]        cap_slot_p [RD_LAT];
    logic [CW-1:0]     cap_col_p  [RD_LAT];

    assign req_row    = clamp_row({1'b0, dst_row});
    assign ld_last    = (state == LOAD) && (ld_col == LAST_COL) && (ld_single || (ld_k == 2'd3));
    assign drain_last = (state == DRAIN) && (drn_cnt == 2'(RD_LAT - 1));
    assign ld_slot    = ld_single ? base : ld_k;

`ifdef ROW_REUSE_EN
    logic [ROW_W-1:0] tag;
    logic             tag_vld;

    assign req_hit    = tag_vld && (req_row == tag);
    assign req_single = tag_vld && ({1'b0, req_row} == ({1'b0, tag} + {{ROW_W{1'b0}}, 1'b1}));

    // Window tag, load mode and rotating base pointer of the row buffers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag       <= '0;
            tag_vld   <= 1'b0;
            ld_single <= 1'b0;
            base      <= 2'd0;
        end else begin
            if (state == IDLE && wr_req) begin
                tag       <= req_row;
                tag_vld   <= 1'b1;
                ld_single <= req_single;
                if (!req_hit && !req_single) begin
                    base <= 2'd0;
                end
            end
            if (drain_last && ld_single) begin
                base <= base + 2'd1;
            end
        end
    end
`else
    assign req_hit    = 1'b0;
    assign req_single = 1'b0;
    assign ld_single  = 1'b0;
    assign base       = 2'd0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and state-decoded status outputs.
    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        tran_done = (state == DONE);
        case (state)
            IDLE:    if (wr_req) state_nx = req_hit ? STREAM : LOAD;
            LOAD:    if (ld_last) state_nx = DRAIN;
            DRAIN:   if (drain_last) state_nx = STREAM;
            STREAM:  if (st_col == SW'(IMG_W)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next read position and frame address, k-major then column ascending.
    always_comb begin
        row_ref      = top_row;
        ld_k_nx      = ld_k;
        ld_col_nx    = ld_col;
        ld_single_nx = ld_single;
        rd_en_nx     = 1'b0;
        if (state == IDLE) begin
            row_ref      = req_row;
            ld_k_nx      = 2'd0;
            ld_col_nx    = '0;
            ld_single_nx = req_single;
            rd_en_nx     = wr_req && !req_hit;
        end else if (state == LOAD) begin
            rd_en_nx = !ld_last;
            if (ld_col == LAST_COL) begin
                ld_col_nx = '0;
                ld_k_nx   = ld_k + 2'd1;
            end else begin
                ld_col_nx = ld_col + CW'(1);
            end
        end
        src_k      = ld_single_nx ? 2'd3 : ld_k_nx;
        rd_addr_nx = rd_en_nx ? pix_addr(src_row(row_ref, src_k), ld_col_nx) : '0;
    end

    // Load/drain/stream sequencing counters and frame-memory read port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            top_row <= '0;
            ld_k    <= 2'd0;
            ld_col  <= '0;
            drn_cnt <= 2'd0;
            st_col  <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            if (state == IDLE && wr_req) begin
                top_row <= req_row;
            end
            ld_k    <= ld_k_nx;
            ld_col  <= ld_col_nx;
            drn_cnt <= (state == DRAIN) ? drn_cnt + 2'd1 : 2'd0;
            st_col  <= (state == STREAM) ? st_col + SW'(1) : '0;
            rd_en   <= rd_en_nx;
            rd_addr <= rd_addr_nx;
        end
    end

    // Capture tag pipeline: (slot, col) travels with each read for RD_LAT cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_vld_p <= '0;
        end else begin
            cap_vld_p[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                cap_vld_p[i] <= cap_vld_p[i-1];
            end
        end
    end

    // Tag payload of the capture pipeline (no reset, qualified by cap_vld_p).
    always_ff @(posedge clk) begin
        cap_slot_p[0] <= ld_slot;
        cap_col_p[0]  <= ld_col;
        for (int i = 1; i < RD_LAT; i++) begin
            cap_slot_p[i] <= cap_slot_p[i-1];
            cap_col_p[i]  <= cap_col_p[i-1];
        end
    end

    // Row-buffer write select from the tag leaving the pipeline.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            buf_we[i] = cap_vld_p[RD_LAT-1] && (cap_slot_p[RD_LAT-1] == 2'(i));
        end
    end

    // Row-buffer read: column 0 is fetched on the edge entering STREAM.
    always_comb begin
        buf_re    = 1'b0;
        buf_raddr = '0;
        if (state == IDLE && wr_req && req_hit) begin
            buf_re = 1'b1;
        end else if (drain_last) begin
            buf_re = 1'b1;
        end else if (state == STREAM && st_col < SW'(IMG_W - 1)) begin
            buf_re    = 1'b1;
            buf_raddr = CW'(st_col + SW'(1));
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_buf
        row_buf #(
            .DEPTH (IMG_W),
            .DW    (DW)
        ) u_row_buf (
            .clk   (clk),
            .we    (buf_we[g]),
            .waddr (cap_col_p[RD_LAT-1]),
            .wdata (rd_data),
            .re    (buf_re),
            .raddr (buf_raddr),
            .rdata (buf_q[g])
        );
    end

    // Registered column outputs; data holds whenever x_valid is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_valid <= 1'b0;
            x1_data <= '0;
            x2_data <= '0;
            x3_data <= '0;
            x4_data <= '0;
        end else if (state == STREAM && st_col < SW'(IMG_W)) begin
            x_valid <= 1'b1;
            x1_data <= buf_q[base];
            x2_data <= buf_q[base + 2'd1];
            x3_data <= buf_q[base + 2'd2];
            x4_data <= buf_q[base + 2'd3];
        end else begin
            x_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_row_window_server.sv
// Scoreboard bench for row_window_server (IMG_W=8, IMG_H=6); memory word = row*16+col.
module tb_row_window_server;

    parameter int RD_LAT = 1;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rstn;
    logic [11:0]   dst_row;
    logic          wr_req;
    logic [15:0]   x1_data, x2_data, x3_data, x4_data;
    logic          x_valid, tran_done, busy, rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;

    row_window_server #(
        .IMG_W(W), .IMG_H(H), .DW(16), .AW(AW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rstn(rstn), .dst_row(dst_row), .wr_req(wr_req),
        .x1_data(x1_data), .x2_data(x2_data), .x3_data(x3_data), .x4_data(x4_data),
        .x_valid(x_valid), .tran_done(tran_done), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] vals; int cyc; } col_t;
    typedef struct { int addr; int cyc; } rd_t;

    col_t col_q[$];
    rd_t  rd_q[$];
    int   done_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [63:0] last_vals;
    int   tag;
    bit   tag_vld;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] word(input logic [AW-1:0] a);
        int ai;
        ai = int'(a);
        return 16'((ai / W) * 16 + ai % W);
    endfunction

    // Frame-memory model with RD_LAT cycles of read latency.
    logic [15:0] mem_pipe [RD_LAT];
    always @(posedge clk) begin
        mem_pipe[0] <= rd_en ? word(rd_addr) : 16'hdead;
        for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign rd_data = mem_pipe[RD_LAT-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got an event at cycle %0d, required none", nm, cyc);
    endtask

    // Monitor: pops expected reads, columns and done pulses as the DUT shows them.
    always @(negedge clk) begin
        if (rd_en) begin
            if (rd_q.size() == 0) unexpected("unexpected_rd_en");
            else begin
                rd_t r;
                r = rd_q.pop_front();
                chk("rd_addr", 64'(rd_addr), 64'(r.addr));
                chk("rd_cycle", 64'(cyc), 64'(r.cyc));
            end
        end
        if (x_valid) begin
            if (col_q.size() == 0) unexpected("unexpected_x_valid");
            else begin
                col_t c;
                c = col_q.pop_front();
                chk("col_data", {x1_data, x2_data, x3_data, x4_data}, c.vals);
                chk("col_cycle", 64'(cyc), 64'(c.cyc));
            end
        end
        if (tran_done) begin
            if (done_q.size() == 0) unexpected("unexpected_tran_done");
            else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        end
    end

    // Issues one request (called at posedge+1) and queues its expected response.
    task automatic request(input int r, output int rq, output int first);
        int rc, mode, s[4], n;
        rc   = (r >= H) ? H - 1 : r;
        mode = 0;
`ifdef ROW_REUSE_EN
        if (tag_vld && rc == tag) mode = 2;
        else if (tag_vld && rc == tag + 1) mode = 1;
        tag     = rc;
        tag_vld = 1'b1;
`endif
        for (int k = 0; k < 4; k++) s[k] = (rc + k > H - 1) ? H - 1 : rc + k;
        rq = cyc;
        n  = 0;
        if (mode == 0) begin
            for (int k = 0; k < 4; k++)
                for (int c = 0; c < W; c++) begin
                    rd_q.push_back('{addr: s[k] * W + c, cyc: rq + 1 + n});
                    n++;
                end
            first = 4 * W + RD_LAT + 2;
        end else if (mode == 1) begin
            for (int c = 0; c < W; c++) rd_q.push_back('{addr: s[3] * W + c, cyc: rq + 1 + c});
            first = W + RD_LAT + 2;
        end else begin
            first = 2;
        end
        for (int c = 0; c < W; c++) begin
            logic [63:0] v;
            v = {16'(s[0] * 16 + c), 16'(s[1] * 16 + c), 16'(s[2] * 16 + c), 16'(s[3] * 16 + c)};
            col_q.push_back('{vals: v, cyc: rq + first + c});
            last_vals = v;
        end
        done_q.push_back(rq + first + W);
        dst_row = 12'(r);
        wr_req  = 1'b1;
        @(posedge clk); #1;
        wr_req  = 1'b0;
    endtask

    task automatic pulse_req(input int r);
        dst_row = 12'(r);
        wr_req  = 1'b1;
        @(posedge clk); #1;
        wr_req  = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    // Waits (bounded) for the DUT to return to IDLE with all expectations consumed.
    task automatic wait_idle(input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (!busy && col_q.size() == 0 && rd_q.size() == 0 && done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_reached", 64'(ok), 64'd1);
        chk("idle_rd_en", 64'(rd_en), 64'd0);
        chk("idle_rd_addr", 64'(rd_addr), 64'd0);
        chk("idle_hold", {x1_data, x2_data, x3_data, x4_data}, last_vals);
    endtask

    task automatic chk_all_zero(input string tagname);
        chk({tagname, "_x"}, {x1_data, x2_data, x3_data, x4_data}, 64'd0);
        chk({tagname, "_ctl"}, {60'd0, x_valid, tran_done, busy, rd_en}, 64'd0);
        chk({tagname, "_rd_addr"}, 64'(rd_addr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rq, first;
        rstn    = 1'b0;
        wr_req  = 1'b0;
        dst_row = '0;
        tag     = 0;
        tag_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Plain window, bottom edge, clamped top row.
        request(1, rq, first);
        wait_idle(200);
        request(4, rq, first);
        wait_idle(200);
        request(9, rq, first);
        wait_idle(200);

        // Requests outside IDLE are dropped.
        request(2, rq, first);
        repeat (5) @(posedge clk);
        #1;
        pulse_req(0);
        wait_until(rq + first + 2);
        pulse_req(5);
        wait_idle(200);
        request(3, rq, first);
        wait_idle(200);

        // Reset while column 3 is on the outputs.
        request(0, rq, first);
        wait_until(rq + first + 3);
        chk("pre_reset_valid", 64'(x_valid), 64'd1);
        rstn = 1'b0;
        #1;
        col_q.delete();
        rd_q.delete();
        done_q.delete();
        tag_vld = 1'b0;
        chk_all_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("post_abort");
        request(5, rq, first);
        wait_idle(200);

        // Window reuse sequence (all full loads when reuse is not built in).
        request(0, rq, first);
        wait_idle(200);
        request(1, rq, first);
        wait_idle(200);
        request(1, rq, first);
        wait_idle(200);
        request(3, rq, first);
        wait_idle(200);

        chk("queues_drained", 64'(col_q.size() + rd_q.size() + done_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
